seq_1010_detector: RTL and testbench
====================================

SEQ_1010_DETECTOR -- requirements
Module: seq_1010_detector

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 din  input  1  serial bit stream, one bit sampled per rising clk edge.
REQ-005 dout_mealy  output  1  Mealy detect flag, combinational from state and din.
REQ-006 dout_moore  output  1  Moore detect flag, decoded from registered state only.

Function
REQ-007 Both paths SHALL detect the bit pattern 1,0,1,0 (oldest first) on din, non-overlapping: after a detection, matching restarts from empty; no bits of a detected pattern are reused.
REQ-008 Mealy path states: M_IDLE, M_1, M_10, M_101 (2-bit register).
REQ-009 Mealy transitions (din=1 / din=0): IDLE->M_1/IDLE; M_1->M_1/M_10; M_10->M_101/IDLE; M_101->M_1/IDLE.
REQ-010 dout_mealy SHALL equal 1 exactly when state==M_101 and din==0, otherwise 0; it asserts in the same cycle the final 0 is presented, before the clock edge.
REQ-011 Moore path states: S_IDLE, S_1, S_10, S_101, S_DET (3-bit register).
REQ-012 Moore transitions (din=1 / din=0): IDLE->S_1/IDLE; S_1->S_1/S_10; S_10->S_101/IDLE; S_101->S_1/S_DET; S_DET->S_1/IDLE.
REQ-013 dout_moore SHALL equal 1 exactly when state==S_DET; it asserts for one full cycle starting at the clock edge that samples the final 0, i.e. one cycle after dout_mealy.
REQ-014 A 1 arriving in M_101/S_101 SHALL return to M_1/S_1 (the new 1 is kept as a prefix), not to idle.
REQ-015 Unused Moore encodings SHALL transition to S_IDLE on the next edge with dout_moore=0.
REQ-016 Both paths SHALL see the identical din and run in lockstep; the paths share no state.

Reset
REQ-017 While rst=0, both state registers SHALL be forced to idle immediately, independent of clk.
REQ-018 During reset, dout_moore=0; dout_mealy=0 regardless of din.
REQ-019 Reset asserted mid-pattern SHALL discard all partial match history; matching restarts from the first edge after rst returns high.

Structure
REQ-020 A shared package SHALL hold the Mealy and Moore state encodings as named constants/enumerated types.
REQ-021 The top SHALL instantiate two leaf sub-modules: non_overlap_1010_mealy and non_overlap_1010_moore, each with ports clk, rst, din, dout.
REQ-022 Each leaf SHALL use a separate state register block and combinational next-state/output logic; no latches.

Verification
REQ-023 Reset, then din 1,1,0,1,0 -> dout_mealy=1 only while the 5th bit is presented; dout_moore=1 for the cycle after the 5th edge; otherwise 0.
REQ-024 Continue with 1,0 (stream 1,1,0,1,0,1,0) -> no pulse on either output for the 7th bit (overlap rejected).
REQ-025 Full stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0 -> exactly two detections per output: at bits 5 and 13 (Moore one cycle later).
REQ-026 Stream 1,0,1,1,0,1,0 -> single detection at bit 7 (1 in M_101 returns to M_1).
REQ-027 Apply 1,0,1 then rst=0 asynchronously mid-cycle, release, then 0 -> no detection; state idle immediately on rst fall.
REQ-028 Constant din=0 or din=1 for 20 cycles -> both outputs stay 0.

Source files
------------

// File: rtl/seq_1010_detector_pkg.sv
// State encodings shared by the Mealy and Moore 1010 detector leaves.
package seq_1010_detector_pkg;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_1    = 2'd1,
        M_10   = 2'd2,
        M_101  = 2'd3
    } mealy_state_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_DET  = 3'd4
    } moore_state_t;

endpackage

// File: rtl/seq_1010_detector_mealy.sv
// Non-overlapping 1010 detector, Mealy form: the flag rises while the final 0 is on din.
module non_overlap_1010_mealy
    import seq_1010_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    mealy_state_t state;
    mealy_state_t next_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= M_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completed match drops back to idle so no bits of it are reused.
    always_comb begin
        next_state = M_IDLE;
        case (state)
            M_IDLE:  next_state = din ? M_1   : M_IDLE;
            M_1:     next_state = din ? M_1   : M_10;
            M_10:    next_state = din ? M_101 : M_IDLE;
            M_101:   next_state = din ? M_1   : M_IDLE;
            default: next_state = M_IDLE;
        endcase
    end

    assign dout = (state == M_101) && !din;

endmodule

// File: rtl/seq_1010_detector_moore.sv
// Non-overlapping 1010 detector, Moore form: the flag is a decode of the S_DET state.
module non_overlap_1010_moore
    import seq_1010_detector_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    moore_state_t state;
    moore_state_t next_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stray encodings fall through the default and recover to idle.
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:  next_state = din ? S_1   : S_IDLE;
            S_1:     next_state = din ? S_1   : S_10;
            S_10:    next_state = din ? S_101 : S_IDLE;
            S_101:   next_state = din ? S_1   : S_DET;
            S_DET:   next_state = din ? S_1   : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign dout = (state == S_DET);

endmodule

// File: rtl/seq_1010_detector.sv
// Runs the Mealy and Moore 1010 detectors side by side on the same serial stream.
module seq_1010_detector (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout_mealy,
    output logic dout_moore
);

    non_overlap_1010_mealy u_mealy (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout_mealy)
    );

    non_overlap_1010_moore u_moore (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout_moore)
    );

endmodule

// File: tb/tb_seq_1010_detector.sv
// Randomised and directed stimulus for seq_1010_detector, checked through a scoreboard
// fed by a bit-history reference model.
module tb_seq_1010_detector;

    logic clk;
    logic rst;
    logic din;
    logic dout_mealy;
    logic dout_moore;

    typedef struct {
        logic mealy;
        logic moore;
        int   idx;
    } sb_entry_t;

    sb_entry_t sb[$];
    bit        hist[$];
    logic      moore_pending;
    int        bit_idx;
    int        n_checks;
    int        n_fail;

    seq_1010_detector dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dout_mealy (dout_mealy),
        .dout_moore (dout_moore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // The pattern is found when the bits kept since the last detection, plus b, end in 1010.
    function automatic logic model_hit(input bit b);
        int n;
        n = hist.size();
        if (n < 3) return 1'b0;
        return hist[n-3] == 1'b1 && hist[n-2] == 1'b0 && hist[n-1] == 1'b1 && b == 1'b0;
    endfunction

    function automatic void model_reset();
        hist.delete();
        moore_pending = 1'b0;
    endfunction

    task automatic apply_stimulus(input logic b);
        sb_entry_t e;
        @(posedge clk);
        #1;
        din     = b;
        e.mealy = model_hit(b);
        e.moore = moore_pending;
        e.idx   = bit_idx;
        sb.push_back(e);
        moore_pending = e.mealy;
        if (e.mealy) hist.delete();
        else         hist.push_back(b);
        bit_idx++;
    endtask

    task automatic apply_seq(input logic [31:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) apply_stimulus(bits[i]);
    endtask

    // Reset lands mid-cycle, after the edge that sampled the previous bit.
    task automatic reset_pulse(input logic drive);
        @(posedge clk);
        #1;
        din = drive;
        #1;
        check_output("pre_reset_mealy", dout_mealy, model_hit(drive));
        check_output("pre_reset_moore", dout_moore, moore_pending);
        rst = 1'b0;
        #1;
        check_output("async_reset_mealy", dout_mealy, 1'b0);
        check_output("async_reset_moore", dout_moore, 1'b0);
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && sb.size() > 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            check_output($sformatf("mealy_bit%0d", e.idx), dout_mealy, e.mealy);
            check_output($sformatf("moore_bit%0d", e.idx), dout_moore, e.moore);
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bit_idx  = 0;
        model_reset();
        rst = 1'b0;
        din = 1'b1;
        #23;
        check_output("reset_mealy_din1", dout_mealy, 1'b0);
        check_output("reset_moore_din1", dout_moore, 1'b0);
        din = 1'b0;
        #1;
        check_output("reset_mealy_din0", dout_mealy, 1'b0);
        check_output("reset_moore_din0", dout_moore, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0 then idle zeros
        apply_seq(32'b110101011101010, 15);
        apply_seq(32'b000, 3);
        // 1,0,1,1,0,1,0 then idle zeros
        apply_seq(32'b1011010, 7);
        apply_seq(32'b00, 2);

        // Reset while Moore sits in S_DET
        apply_seq(32'b1010, 4);
        reset_pulse(1'b0);
        apply_seq(32'b00, 2);

        // Reset after 1,0,1 with the final 0 already on din
        apply_seq(32'b101, 3);
        reset_pulse(1'b0);
        apply_seq(32'b0101, 4);
        apply_seq(32'b00, 2);

        for (int i = 0; i < 20; i++) apply_stimulus(1'b0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1);

        for (int i = 0; i < 400; i++) begin
            if (i % 8 < 6) apply_stimulus(logic'($urandom_range(0, 1)));
            else           apply_stimulus(logic'(i % 2));
        end
        apply_stimulus(1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check_output("scoreboard_drained", logic'(sb.size() == 0), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
